// File: rtl/spi_ram_ctrl_if.sv
// Frame/read-data bundle between the SPI slave and the command-decoding RAM.
//
// Handshake: rx_valid is a one-cycle qualifier for din; a frame is consumed on
// every rising clk edge that sees rx_valid=1, with no back-pressure. tx_valid
// flags that dout holds fresh read data and stays high until the next
// consumed frame.
interface spi_ram_ctrl_if #(
   parameter int ADDR_SIZE = 8
);
   logic [ADDR_SIZE+1:0] din;
   logic                 rx_valid;
   logic [ADDR_SIZE-1:0] dout;
   logic                 tx_valid;
   logic                 cmd_err;

   // SPI slave side: delivers frames, receives read bytes
   modport master (
      output din, rx_valid,
      input  dout, tx_valid, cmd_err
   );

   // RAM side: consumes frames, returns read bytes
   modport slave (
      input  din, rx_valid,
      output dout, tx_valid, cmd_err
   );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM fed by 10-bit SPI frames.
// Frame = {cmd[1:0], payload[ADDR_SIZE-1:0]}; commands load write/read
// pointers or move one byte through an auto-incrementing pointer.
module spi_ram_ctrl #(
   parameter int ADDR_SIZE = 8,
   parameter int MEM_DEPTH = 256
) (
   input logic           clk,
   input logic           rst_n,
   spi_ram_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

   logic [ADDR_SIZE-1:0] wr_ptr;
   logic [ADDR_SIZE-1:0] rd_ptr;
   logic                 wr_armed;
   logic                 rd_armed;
   logic [ADDR_SIZE-1:0] dout_q;
   logic                 tx_valid_q;
   logic                 cmd_err_q;

   cmd_e                 cmd;
   logic [ADDR_SIZE-1:0] pay;
   logic                 wr_ok;
   logic                 rd_ok;
   logic                 reject;

   // Decode the incoming frame and classify it as accepted or rejected
   always_comb begin
      cmd    = cmd_e'(bus.din[ADDR_SIZE+1:ADDR_SIZE]);
      pay    = bus.din[ADDR_SIZE-1:0];
      wr_ok  = 1'b0;
      rd_ok  = 1'b0;
      reject = 1'b0;
      if (bus.rx_valid) begin
         wr_ok  = (cmd == CMD_WR_DATA) && wr_armed;
         rd_ok  = (cmd == CMD_RD_DATA) && rd_armed;
         reject = ((cmd == CMD_WR_DATA) && !wr_armed) ||
                  ((cmd == CMD_RD_DATA) && !rd_armed);
      end
   end

   // Storage array: no reset so contents survive rst_n pulses
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= pay;
      end
   end

   // Pointers, armed flags, read-data register and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wr_armed   <= 1'b0;
         rd_armed   <= 1'b0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else if (bus.rx_valid) begin
         // Any consumed frame retires the current read byte; only a good
         // RD_DATA replaces it.
         tx_valid_q <= rd_ok;
         if (reject) begin
            cmd_err_q <= 1'b1;
         end
         if (cmd == CMD_WR_ADDR) begin
            wr_ptr   <= pay;
            wr_armed <= 1'b1;
         end
         if (cmd == CMD_RD_ADDR) begin
            rd_ptr   <= pay;
            rd_armed <= 1'b1;
         end
         if (wr_ok) begin
            wr_ptr <= wr_ptr + ADDR_SIZE'(1);
         end
         if (rd_ok) begin
            dout_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + ADDR_SIZE'(1);
         end
      end
   end

   assign bus.dout     = dout_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed and randomized frames against a byte-array reference model.
module tb_spi_ram_ctrl;

   localparam int AW = 8;

   logic clk;
   logic rst_n;

   spi_ram_ctrl_if #(.ADDR_SIZE(AW)) bus ();

   spi_ram_ctrl #(.ADDR_SIZE(AW), .MEM_DEPTH(256)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [7:0] m_mem [256];
   logic [7:0] m_wp, m_rp, m_dout;
   logic       m_wa, m_ra, m_txv, m_err;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".dout"},     32'(bus.dout),     32'(m_dout));
      check({tag, ".tx_valid"}, 32'(bus.tx_valid), 32'(m_txv));
      check({tag, ".cmd_err"},  32'(bus.cmd_err),  32'(m_err));
   endtask

   // async reset pulse; memory model is left untouched
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      m_wp = 0; m_rp = 0; m_wa = 0; m_ra = 0;
      m_dout = 0; m_txv = 0; m_err = 0;
      check_model("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // drive one frame across one rising edge, update model from the command rules
   task automatic send(input logic [9:0] frame);
      logic [1:0] c;
      logic [7:0] p;
      c = frame[9:8];
      p = frame[7:0];
      bus.din      = frame;
      bus.rx_valid = 1'b1;
      m_txv = 1'b0;
      case (c)
         2'b00: begin m_wp = p; m_wa = 1'b1; end
         2'b01: begin
            if (m_wa) begin m_mem[m_wp] = p; m_wp = m_wp + 8'd1; end
            else m_err = 1'b1;
         end
         2'b10: begin m_rp = p; m_ra = 1'b1; end
         default: begin
            if (m_ra) begin
               m_dout = m_mem[m_rp]; m_txv = 1'b1; m_rp = m_rp + 8'd1;
            end else m_err = 1'b1;
         end
      endcase
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.din      = $urandom_range(0, 1023);
      check_model("frame");
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      check_model("idle");
   endtask

   initial begin
      rst_n        = 1'b1;
      bus.din      = '0;
      bus.rx_valid = 1'b0;
      for (int i = 0; i < 256; i++) m_mem[i] = 'x;

      // 1: reset values, then unarmed read is rejected
      do_reset();
      check("t1.dout", 32'(bus.dout), 0);
      check("t1.txv",  32'(bus.tx_valid), 0);
      check("t1.err",  32'(bus.cmd_err), 0);
      send(10'h300);
      check("t1.rd_err", 32'(bus.cmd_err), 1);
      check("t1.rd_txv", 32'(bus.tx_valid), 0);

      // fill whole memory with a known pattern so every read is defined
      send(10'h000);
      for (int i = 0; i < 256; i++) send({2'b01, 8'(i) ^ 8'h5A});

      // 2: basic write/read
      do_reset();
      send(10'h012); send(10'h1AB); send(10'h212); send(10'h300);
      check("t2.dout", 32'(bus.dout), 32'hAB);
      check("t2.txv",  32'(bus.tx_valid), 1);
      check("t2.err",  32'(bus.cmd_err), 0);

      // 3: burst with pointer wrap
      send(10'h0FE); send(10'h111); send(10'h122); send(10'h133);
      send(10'h2FE);
      send(10'h300); check("t3.rd0", 32'(bus.dout), 32'h11);
      send(10'h300); check("t3.rd1", 32'(bus.dout), 32'h22);
      send(10'h300); check("t3.rd2", 32'(bus.dout), 32'h33);

      // hold while idle
      idle(3);
      check("hold.txv", 32'(bus.tx_valid), 1);

      // 4: any other frame retires tx_valid, dout holds
      send(10'h005);
      check("t4.txv",  32'(bus.tx_valid), 0);
      check("t4.dout", 32'(bus.dout), 32'h33);

      // 5: unarmed write rejected, mem[0] keeps the byte written in t3
      do_reset();
      send(10'h155);
      check("t5.err", 32'(bus.cmd_err), 1);
      send(10'h000); send(10'h200); send(10'h300);
      check("t5.dout", 32'(bus.dout), 32'h33);

      // 6: reset between RD_ADDR and RD_DATA disarms the read
      send(10'h210);
      do_reset();
      send(10'h300);
      check("t6.err", 32'(bus.cmd_err), 1);
      check("t6.txv", 32'(bus.tx_valid), 0);
      do_reset();
      send(10'h210); send(10'h300);
      check("t6.mem", 32'(bus.dout), 32'h10 ^ 32'h5A);

      // randomized frames, idles and occasional resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 60) == 0) do_reset();
         send(10'($urandom_range(0, 1023)));
         if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // overall time bound
   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
